mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / load-store memory arbiter:
// FSM state encodings and the default fetch-starvation limit.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_LS = 2'd1,
        ST_BUSY_IF = 2'd2
    } arb_state_e;

    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between load/store and instruction fetch,
// one outstanding transaction at a time, with a bounded fetch starvation window.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ls_req_i,
    input  logic [3:0]  ls_wen_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,

    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wen_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        hold_flag_o
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_e       state;
    arb_state_e       state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_next;

    logic if_wins;
    logic ls_wins;

    // Fetch normally yields to load/store, but takes the port once it has
    // watched STARVE_MAX consecutive load/store grants go by.
    assign if_wins = if_req_i && (!ls_req_i || (starve_cnt == CNT_MAX));
    assign ls_wins = ls_req_i && !if_wins;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        starve_cnt_next = starve_cnt;

        ls_gnt_o    = 1'b0;
        if_gnt_o    = 1'b0;
        ls_rvalid_o = 1'b0;
        ls_rdata_o  = 32'h0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = 32'h0;
        mem_req_o   = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wen_o   = 4'b0000;
        mem_wdata_o = 32'h0;
        hold_flag_o = 1'b0;

        if (!rst) begin
            unique case (state)
                ST_IDLE: begin
                    if (if_wins) begin
                        mem_req_o  = 1'b1;
                        mem_addr_o = if_addr_i;
                    end else if (ls_wins) begin
                        mem_req_o   = 1'b1;
                        mem_addr_o  = ls_addr_i;
                        mem_wen_o   = ls_wen_i;
                        mem_wdata_o = ls_wdata_i;
                    end

                    ls_gnt_o    = mem_gnt_i && ls_wins;
                    if_gnt_o    = mem_gnt_i && if_wins;
                    hold_flag_o = ls_req_i && !ls_gnt_o;

                    if (ls_gnt_o) begin
                        state_next = ST_BUSY_LS;
                    end else if (if_gnt_o) begin
                        state_next = ST_BUSY_IF;
                    end
                end

                ST_BUSY_LS: begin
                    ls_rvalid_o = mem_rvalid_i;
                    ls_rdata_o  = mem_rvalid_i ? mem_rdata_i : 32'h0;
                    hold_flag_o = !mem_rvalid_i;
                    if (mem_rvalid_i) begin
                        state_next = ST_IDLE;
                    end
                end

                ST_BUSY_IF: begin
                    if_rvalid_o = mem_rvalid_i;
                    if_rdata_o  = mem_rvalid_i ? mem_rdata_i : 32'h0;
                    hold_flag_o = ls_req_i;
                    if (mem_rvalid_i) begin
                        state_next = ST_IDLE;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase

            // The count only means something while fetch is actually waiting.
            if (!if_req_i || if_gnt_o) begin
                starve_cnt_next = '0;
            end else if (ls_gnt_o && (starve_cnt != CNT_MAX)) begin
                starve_cnt_next = starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level
// model of the arbitration rules.
module tb_mem_arbiter;

    localparam int SM = 4;

    logic        clk;
    logic        rst;
    logic        ls_req_i;
    logic [3:0]  ls_wen_i;
    logic [31:0] ls_addr_i;
    logic [31:0] ls_wdata_i;
    logic        ls_gnt_o;
    logic        ls_rvalid_o;
    logic [31:0] ls_rdata_o;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_wen_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        hold_flag_o;

    mem_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .ls_req_i(ls_req_i), .ls_wen_i(ls_wen_i), .ls_addr_i(ls_addr_i),
        .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
        .ls_rdata_o(ls_rdata_o),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .hold_flag_o(hold_flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Model: who owns the outstanding transaction (0 none, 1 ls, 2 if) and
    // how many load/store grants fetch has watched go by.
    int pend   = 0;
    int starve = 0;

    // Snapshot of DUT outputs from the most recent cycle, for literal checks.
    logic        s_ls_gnt, s_if_gnt, s_ls_rv, s_if_rv, s_mreq, s_hold;
    logic [31:0] s_ls_rd, s_if_rd, s_maddr, s_mwdata;
    logic [3:0]  s_mwen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called with inputs already applied just after a rising edge; checks the
    // combinational outputs, then advances the model across the next edge.
    task automatic cycle();
        bit e_lsg, e_ifg, e_mreq, e_lsrv, e_ifrv, e_hold, ifw, any;
        #1;
        e_lsg = 0; e_ifg = 0; e_mreq = 0; e_lsrv = 0; e_ifrv = 0; e_hold = 0;
        ifw = 0; any = 0;
        if (rst) begin
            chk("rst_mem_addr", mem_addr_o, 32'h0);
            chk("rst_mem_wdata", mem_wdata_o, 32'h0);
            chk("rst_mem_wen", {28'h0, mem_wen_o}, 32'h0);
        end else if (pend == 0) begin
            ifw    = if_req_i && (!ls_req_i || starve == SM);
            any    = ls_req_i || if_req_i;
            e_mreq = any;
            e_lsg  = mem_gnt_i && any && !ifw;
            e_ifg  = mem_gnt_i && ifw;
            e_hold = ls_req_i && !e_lsg;
            if (!any) begin
                chk("idle_mem_wen", {28'h0, mem_wen_o}, 32'h0);
            end else if (ifw) begin
                chk("if_mem_addr", mem_addr_o, if_addr_i);
                chk("if_mem_wen", {28'h0, mem_wen_o}, 32'h0);
            end else begin
                chk("ls_mem_addr", mem_addr_o, ls_addr_i);
                chk("ls_mem_wen", {28'h0, mem_wen_o}, {28'h0, ls_wen_i});
                chk("ls_mem_wdata", mem_wdata_o, ls_wdata_i);
            end
        end else begin
            e_lsrv = (pend == 1) && mem_rvalid_i;
            e_ifrv = (pend == 2) && mem_rvalid_i;
            e_hold = ((pend == 1) && !mem_rvalid_i) || ((pend == 2) && ls_req_i);
        end
        chk("ls_gnt", {31'h0, ls_gnt_o}, {31'h0, e_lsg});
        chk("if_gnt", {31'h0, if_gnt_o}, {31'h0, e_ifg});
        chk("mem_req", {31'h0, mem_req_o}, {31'h0, e_mreq});
        chk("ls_rvalid", {31'h0, ls_rvalid_o}, {31'h0, e_lsrv});
        chk("if_rvalid", {31'h0, if_rvalid_o}, {31'h0, e_ifrv});
        chk("ls_rdata", ls_rdata_o, e_lsrv ? mem_rdata_i : 32'h0);
        chk("if_rdata", if_rdata_o, e_ifrv ? mem_rdata_i : 32'h0);
        chk("hold_flag", {31'h0, hold_flag_o}, {31'h0, e_hold});

        s_ls_gnt = ls_gnt_o;   s_if_gnt = if_gnt_o;
        s_ls_rv  = ls_rvalid_o; s_if_rv = if_rvalid_o;
        s_ls_rd  = ls_rdata_o;  s_if_rd = if_rdata_o;
        s_mreq   = mem_req_o;   s_maddr = mem_addr_o;
        s_mwen   = mem_wen_o;   s_mwdata = mem_wdata_o;
        s_hold   = hold_flag_o;

        @(posedge clk);
        if (rst) begin
            pend = 0; starve = 0;
        end else begin
            if (pend == 0) begin
                if (e_lsg) pend = 1;
                else if (e_ifg) pend = 2;
            end else if (mem_rvalid_i) begin
                pend = 0;
            end
            if (!if_req_i || e_ifg) starve = 0;
            else if (e_lsg && starve < SM) starve = starve + 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        ls_req_i = 0; ls_wen_i = 0; ls_addr_i = 0; ls_wdata_i = 0;
        if_req_i = 0; if_addr_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    string gseq;

    initial begin
        rst = 1;
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_mem_req", {31'h0, s_mreq}, 32'h0);
        chk("reset_hold", {31'h0, s_hold}, 32'h0);

        // Load at 0x100, response two cycles after the grant.
        ls_req_i = 1; ls_addr_i = 32'h100; mem_gnt_i = 1;
        cycle();
        chk("ld_gnt_c0", {31'h0, s_ls_gnt}, 32'h1);
        chk("ld_addr_c0", s_maddr, 32'h100);
        ls_req_i = 0; mem_gnt_i = 0;
        cycle();
        chk("ld_hold_c1", {31'h0, s_hold}, 32'h1);
        mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        cycle();
        chk("ld_rvalid_c2", {31'h0, s_ls_rv}, 32'h1);
        chk("ld_rdata_c2", s_ls_rd, 32'hDEADBEEF);
        idle_inputs();
        cycle();

        // Full-word store.
        ls_req_i = 1; ls_wen_i = 4'b1111; ls_wdata_i = 32'h12345678;
        ls_addr_i = 32'h40; mem_gnt_i = 1;
        cycle();
        chk("st_wen", {28'h0, s_mwen}, 32'hF);
        chk("st_wdata", s_mwdata, 32'h12345678);
        idle_inputs();
        cycle();
        mem_rvalid_i = 1;
        cycle();
        chk("st_ack", {31'h0, s_ls_rv}, 32'h1);
        idle_inputs();
        cycle();

        // Simultaneous requests: load/store first, fetch after one IDLE cycle.
        ls_req_i = 1; ls_addr_i = 32'h200; if_req_i = 1; if_addr_i = 32'h0;
        mem_gnt_i = 1;
        cycle();
        chk("both_ls_first", {31'h0, s_ls_gnt}, 32'h1);
        chk("both_if_wait", {31'h0, s_if_gnt}, 32'h0);
        ls_req_i = 0;
        cycle();
        mem_rvalid_i = 1;
        cycle();
        chk("both_if_not_on_resp", {31'h0, s_if_gnt}, 32'h0);
        mem_rvalid_i = 0;
        cycle();
        chk("both_if_gnt", {31'h0, s_if_gnt}, 32'h1);
        if_req_i = 0; mem_gnt_i = 0;
        cycle();
        mem_rvalid_i = 1; mem_rdata_i = 32'h00000013;
        cycle();
        chk("if_resp", {31'h0, s_if_rv}, 32'h1);
        chk("if_resp_data", s_if_rd, 32'h00000013);
        idle_inputs();
        cycle();

        // Both held high with a single-cycle memory: starvation pattern.
        ls_req_i = 1; if_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
        gseq = "";
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_ls_gnt) gseq = {gseq, "L"};
            if (s_if_gnt) gseq = {gseq, "I"};
        end
        vectors++;
        if (gseq != "LLLLILLLLI") begin
            errors++;
            $display("FAIL starve_pattern: got %s, expected LLLLILLLLI", gseq);
        end
        idle_inputs();
        cycle();
        cycle();

        // Memory stalls for three cycles.
        ls_req_i = 1; ls_addr_i = 32'h80;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_mem_req", {31'h0, s_mreq}, 32'h1);
            chk("stall_hold", {31'h0, s_hold}, 32'h1);
            chk("stall_no_gnt", {31'h0, s_ls_gnt}, 32'h0);
        end
        mem_gnt_i = 1;
        cycle();
        chk("stall_gnt", {31'h0, s_ls_gnt}, 32'h1);
        idle_inputs();
        cycle();
        mem_rvalid_i = 1;
        cycle();
        idle_inputs();
        cycle();

        // Reset while a fetch is outstanding abandons the response.
        if_req_i = 1; if_addr_i = 32'h400; mem_gnt_i = 1;
        cycle();
        chk("rst_if_gnt", {31'h0, s_if_gnt}, 32'h1);
        idle_inputs();
        cycle();
        rst = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D;
        cycle();
        chk("rst_if_rvalid", {31'h0, s_if_rv}, 32'h0);
        rst = 0;
        cycle();
        chk("post_rst_if_rvalid", {31'h0, s_if_rv}, 32'h0);
        chk("post_rst_mem_req", {31'h0, s_mreq}, 32'h0);
        idle_inputs();
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(63) == 0);
            ls_req_i     = ($urandom_range(9) < 6);
            ls_wen_i     = ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom);
            ls_addr_i    = $urandom;
            ls_wdata_i   = $urandom;
            if_req_i     = ($urandom_range(1) == 0);
            if_addr_i    = $urandom;
            mem_gnt_i    = ($urandom_range(9) < 7);
            mem_rvalid_i = ($urandom_range(1) == 0);
            mem_rdata_i  = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
